// File: rtl/bit_serializer.sv
// Bit serializer: parallel word in, timed serial bit stream out,
// with a valid/ready load handshake and an end-of-word pulse.
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LAST  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [BW-1:0]    bit_cnt;
    logic [CW-1:0]    cyc_cnt;
    logic             accept;
    logic             bit_end;
    logic             word_end;

    assign accept   = load_valid && ((state == IDLE) || (state == LAST));
    assign bit_end  = (state == SHIFT) && (cyc_cnt == CYC_LAST);
    assign word_end = bit_end && (bit_cnt == BIT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The 2'b11 encoding falls into the default and recovers to IDLE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = load_valid ? SHIFT : IDLE;
            SHIFT:   state_nxt = word_end ? LAST : SHIFT;
            LAST:    state_nxt = load_valid ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sreg    <= '0;
            bit_cnt <= '0;
            cyc_cnt <= '0;
        end else if (accept) begin
            sreg    <= load_data;
            bit_cnt <= '0;
            cyc_cnt <= '0;
        end else if (state == SHIFT) begin
            if (bit_end) begin
                cyc_cnt <= '0;
                sreg    <= MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, sreg[WIDTH-1:1]};
                // Hold on the final bit so the counter never wraps.
                if (!word_end) begin
                    bit_cnt <= bit_cnt + BW'(1);
                end
            end else begin
                cyc_cnt <= cyc_cnt + CW'(1);
            end
        end
    end

    assign busy       = (state == SHIFT);
    assign x_valid    = (state == SHIFT);
    assign done       = (state == LAST);
    assign load_ready = (state == IDLE) || (state == LAST);
    assign x          = (state == SHIFT) &&
                        (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8, number of bits per word (range 2..32).
REQ-002 Parameter BIT_CYCLES, default 1, clock cycles each serial bit is held (range 1..255).
REQ-003 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 load_data  input  WIDTH  parallel word to serialize.
REQ-007 load_valid  input  1  producer offers load_data this cycle.
REQ-008 load_ready  output  1  block accepts a word this cycle.
REQ-009 x  output  1  serial bit stream feeding the downstream Moore detector input.
REQ-010 x_valid  output  1  x carries a word bit this cycle.
REQ-011 busy  output  1  a word is being shifted out.
REQ-012 done  output  1  one-cycle pulse after the last bit period of a word.

Function
REQ-013 The block SHALL implement FSM states IDLE, SHIFT, LAST.
REQ-014 IDLE: load_ready=1, x=0, x_valid=0, busy=0; load_valid=1 at a rising edge SHALL capture load_data into a shift register, clear bit counter and cycle counter, go to SHIFT.
REQ-015 A transfer SHALL occur only on an edge where load_valid=1 and load_ready=1; load_data outside that edge SHALL be ignored.
REQ-016 SHIFT: load_ready=0, busy=1, x_valid=1, x = current bit (MSB or LSB of shift register per MSB_FIRST).
REQ-017 Each bit SHALL be held exactly BIT_CYCLES cycles via a cycle counter counting 0..BIT_CYCLES-1.
REQ-018 At the end of each bit period the shift register SHALL shift by one toward the output end and the bit counter SHALL increment.
REQ-019 At the end of the bit period of bit number WIDTH-1 the FSM SHALL go to LAST.
REQ-020 LAST: done=1, load_ready=1, x=0, x_valid=0, busy=0, for exactly one cycle; next state IDLE, or SHIFT if a word is accepted in that cycle (same capture as REQ-014).
REQ-021 Latency: first bit SHALL appear on x in the cycle immediately after the accepting edge.
REQ-022 A word SHALL occupy x_valid for exactly WIDTH*BIT_CYCLES consecutive cycles; back-to-back words SHALL be separated by exactly one cycle with x_valid=0 (the LAST cycle).
REQ-023 All outputs SHALL be driven from registers or from the state register only; no combinational path from load_valid or load_data to any output.
REQ-024 Counters SHALL be sized to hold WIDTH-1 and BIT_CYCLES-1 without wrap; no counter SHALL wrap during normal operation.
REQ-025 load_valid held high while busy SHALL have no effect; the pending word is accepted in the next LAST or IDLE cycle.
REQ-026 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-027 reset=1 SHALL immediately force IDLE, clear shift register and counters, and drive x=0, x_valid=0, busy=0, done=0, load_ready=1.
REQ-028 reset asserted mid-word SHALL abort the word with no done pulse; after release the block SHALL wait in IDLE for a new load.
REQ-029 First accept after reset release SHALL be possible on the first rising edge with reset=0.

Verification
REQ-030 WIDTH=8, BIT_CYCLES=1, MSB_FIRST=1, load 8'hB2 -> x = 1,0,1,1,0,0,1,0 on 8 consecutive cycles, x_valid=1 throughout, done=1 on cycle 9.
REQ-031 MSB_FIRST=0, load 8'hB2 -> x = 0,1,0,0,1,1,0,1; done on cycle 9.
REQ-032 BIT_CYCLES=3, load 8'h0F -> each bit held 3 cycles, x_valid high 24 cycles, done on cycle 25.
REQ-033 load_valid held high with words 8'hA5 then 8'h3C -> second word accepted in LAST cycle, exactly one x_valid=0 gap, both sequences correct, two done pulses.
REQ-034 Assert reset during bit 4 of 8'hFF -> outputs reset asynchronously, no done, next load 8'h01 serializes correctly.
REQ-035 Drive x into the downstream detector with word 8'hE0 -> detector sees three consecutive 1s and its z output follows its own state sequence without glitches on x.
